// File: rtl/ncc_sched_pkg.sv
// Shared types and constants for the NCC array control sequencer.
package ncc_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DESC_LOAD,
    S_WIN_STREAM,
    S_DRAIN,
    S_DONE
  } ncc_sched_state_t;

  localparam int DESC_PIX_PER_WORD = 4;
  localparam int DEF_ROWS          = 16;
  localparam int DEF_COLS          = 16;
  localparam int DESC_WORDS        = DEF_ROWS * DEF_COLS / DESC_PIX_PER_WORD;

endpackage

// File: rtl/ncc_sched_addr_gen.sv
// Two-level wrapping counter: inner runs 0..INNER_N-1, outer steps on each inner wrap.
module ncc_sched_addr_gen #(
  parameter int INNER_N = 4,
  parameter int OUTER_N = 16,
  parameter int IW      = 2,
  parameter int OW      = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  output logic [IW-1:0] inner,
  output logic [OW-1:0] outer,
  output logic          wrap
);

  logic inner_last;

  assign inner_last = (inner == IW'(INNER_N - 1));
  assign wrap       = inner_last && (outer == OW'(OUTER_N - 1));

  // clr has priority over en so an abort on a handshake cycle leaves the count at zero
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      inner <= '0;
      outer <= '0;
    end else if (en) begin
      if (inner_last) begin
        inner <= '0;
        outer <= wrap ? '0 : outer + 1'b1;
      end else begin
        inner <= inner + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ncc_scheduler.sv
// Descriptor/window sequencer for the 16x16 log-domain NCC PE array.
// Define NCC_SCHED_PERF_EN to add the stall_cycles performance counter.
module ncc_scheduler
  import ncc_sched_pkg::*;
#(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int WIN_W = 640,
  parameter int WIN_H = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         desc_valid,
  input  logic [31:0]                  desc_data,
  output logic                         desc_ready,
  input  logic                         win_valid,
  input  logic [7:0]                   win_pixel,
  output logic                         win_ready,
  output logic                         load_desc_en,
  output logic [$clog2(ROWS)-1:0]      desc_row,
  output logic [$clog2(COLS/4)-1:0]    desc_col_group,
  output logic [31:0]                  desc_word,
  output logic [7:0]                   win_pixel_out,
  output logic                         load_win_reg,
  output logic                         load_acc_sum_reg,
  output logic                         result_valid,
  output logic [$clog2(WIN_W)-1:0]     result_x,
  output logic [$clog2(WIN_H)-1:0]     result_y,
  output logic                         busy,
  output logic                         done
`ifdef NCC_SCHED_PERF_EN
  ,
  output logic [31:0]                  stall_cycles
`endif
);

  localparam int GROUPS = COLS / DESC_PIX_PER_WORD;
  localparam int RW     = $clog2(ROWS);
  localparam int GW     = $clog2(GROUPS);
  localparam int XW     = $clog2(WIN_W);
  localparam int YW     = $clog2(WIN_H);

  ncc_sched_state_t state;

  logic          desc_hs, win_hs, start_go, kill, cnt_clr;
  logic [GW-1:0] grp_cnt;
  logic [RW-1:0] row_cnt;
  logic          desc_last;
  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;
  logic          win_last;
  logic          res_pend;
  logic [XW-1:0] res_x_pend;
  logic [YW-1:0] res_y_pend;

  assign desc_ready = (state == S_DESC_LOAD);
  assign win_ready  = (state == S_WIN_STREAM);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign desc_hs    = desc_ready && desc_valid;
  assign win_hs     = win_ready && win_valid;
  assign kill       = abort && (state != S_IDLE);
  assign start_go   = (state == S_IDLE) && start && !abort;
  assign cnt_clr    = start_go || kill;

  ncc_sched_addr_gen #(
    .INNER_N(GROUPS), .OUTER_N(ROWS), .IW(GW), .OW(RW)
  ) u_desc_addr (
    .clk(clk), .rst(rst), .en(desc_hs), .clr(cnt_clr),
    .inner(grp_cnt), .outer(row_cnt), .wrap(desc_last)
  );

  ncc_sched_addr_gen #(
    .INNER_N(WIN_W), .OUTER_N(WIN_H), .IW(XW), .OW(YW)
  ) u_win_addr (
    .clk(clk), .rst(rst), .en(win_hs), .clr(cnt_clr),
    .inner(x_cnt), .outer(y_cnt), .wrap(win_last)
  );

  // Abort drops every pending pulse, including a result still one stage from the output
  always_ff @(posedge clk) begin
    if (rst || kill) begin
      state            <= S_IDLE;
      load_desc_en     <= 1'b0;
      desc_row         <= '0;
      desc_col_group   <= '0;
      desc_word        <= '0;
      win_pixel_out    <= '0;
      load_win_reg     <= 1'b0;
      load_acc_sum_reg <= 1'b0;
      res_pend         <= 1'b0;
      res_x_pend       <= '0;
      res_y_pend       <= '0;
      result_valid     <= 1'b0;
      result_x         <= '0;
      result_y         <= '0;
    end else begin
      load_desc_en     <= desc_hs;
      load_win_reg     <= win_hs;
      load_acc_sum_reg <= win_hs;
      res_pend         <= win_hs && (x_cnt >= XW'(COLS - 1));
      result_valid     <= res_pend;
      if (res_pend) begin
        result_x <= res_x_pend;
        result_y <= res_y_pend;
      end
      if (desc_hs) begin
        desc_word      <= desc_data;
        desc_row       <= row_cnt;
        desc_col_group <= grp_cnt;
      end
      if (win_hs) begin
        win_pixel_out <= win_pixel;
        res_x_pend    <= x_cnt - XW'(COLS - 1);
        res_y_pend    <= y_cnt;
      end
      case (state)
        S_IDLE:       if (start_go) state <= S_DESC_LOAD;
        S_DESC_LOAD:  if (desc_hs && desc_last) state <= S_WIN_STREAM;
        S_WIN_STREAM: if (win_hs && win_last) state <= S_DRAIN;
        S_DRAIN:      state <= S_DONE;
        S_DONE:       state <= S_IDLE;
        default:      state <= S_IDLE;
      endcase
    end
  end

`ifdef NCC_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || start_go) begin
      stall_cycles <= '0;
    end else if (win_ready && !win_valid && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end
`endif

endmodule
